// File: rtl/atm_ledger_arbiter_pkg.sv
// Shared encodings and default sizes for the ATM ledger arbiter.
package atm_pkg;

  localparam int DEF_BALANCE_WIDTH = 20;
  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_NUM_ACCT      = 8;
  localparam int ACCT_WIDTH        = 3;
  localparam int ID_WIDTH          = 2;

  typedef enum logic [1:0] {
    OP_WITHDRAW = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_INQUIRY  = 2'b10,
    OP_ILLEGAL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/atm_ledger_arbiter_if.sv
// Requester/ledger bus: packed per-requester request fields, preload port and response.
interface atm_ledger_arbiter_if import atm_pkg::*; #(
  parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]               req;
  logic [2*NUM_REQ-1:0]             req_op;
  logic [ACCT_WIDTH*NUM_REQ-1:0]    req_acct;
  logic [BALANCE_WIDTH*NUM_REQ-1:0] req_value;
  logic                             init_en;
  logic [ACCT_WIDTH-1:0]            init_acct;
  logic [BALANCE_WIDTH-1:0]         init_balance;
  logic [NUM_REQ-1:0]               gnt;
  logic                             busy;
  logic                             done;
  logic                             error;
  logic [ID_WIDTH-1:0]              rsp_id;
  logic [BALANCE_WIDTH-1:0]         rsp_balance;

  modport master (
    output req, req_op, req_acct, req_value, init_en, init_acct, init_balance,
    input  gnt, busy, done, error, rsp_id, rsp_balance
  );

  modport slave (
    input  req, req_op, req_acct, req_value, init_en, init_acct, init_balance,
    output gnt, busy, done, error, rsp_id, rsp_balance
  );

endinterface

// File: rtl/atm_ledger_arbiter_rr.sv
// Round-robin selector: first active requester after the last-granted index, wrapping.
module rr_arbiter import atm_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]  winner,
  output logic [ID_WIDTH-1:0] winner_idx,
  output logic                valid
);

  int                  cand;
  logic [ID_WIDTH-1:0] cand_idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_WIDTH'(cand);
      if (!valid && req[cand_idx]) begin
        valid            = 1'b1;
        winner_idx       = cand_idx;
        winner[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Multi-requester ATM ledger: round-robin grant, then a fixed read/exec/write/respond pass.
module atm_ledger_arbiter import atm_pkg::*; #(
  parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int NUM_ACCT      = DEF_NUM_ACCT
) (
  input logic               clk,
  input logic               rst,
  atm_ledger_arbiter_if.slave bus
);

  state_e                   state_q, state_d;
  logic [BALANCE_WIDTH-1:0] ledger [NUM_ACCT];
  logic [ID_WIDTH-1:0]      last_q, id_q, win_idx;
  logic [NUM_REQ-1:0]       win_onehot;
  logic                     win_valid;
  op_e                      op_q, sel_op;
  logic [ACCT_WIDTH-1:0]    acct_q, sel_acct;
  logic [BALANCE_WIDTH-1:0] val_q, sel_val, bal_q, new_q, exec_new;
  logic                     err_q, exec_err;
  logic [BALANCE_WIDTH:0]   sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .last       (last_q),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  assign bus.busy = (state_q != ST_IDLE);

  always_comb begin
    sel_op   = OP_INQUIRY;
    sel_acct = '0;
    sel_val  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_op   = op_e'(bus.req_op[2*i +: 2]);
        sel_acct = bus.req_acct[ACCT_WIDTH*i +: ACCT_WIDTH];
        sel_val  = bus.req_value[BALANCE_WIDTH*i +: BALANCE_WIDTH];
      end
    end
  end

  // Deposit overflow is detected on the carry so the balance never wraps.
  always_comb begin
    sum      = {1'b0, bal_q} + {1'b0, val_q};
    exec_err = 1'b0;
    exec_new = bal_q;
    case (op_q)
      OP_WITHDRAW: if (val_q > bal_q) exec_err = 1'b1; else exec_new = bal_q - val_q;
      OP_DEPOSIT:  if (sum[BALANCE_WIDTH]) exec_err = 1'b1; else exec_new = sum[BALANCE_WIDTH-1:0];
      OP_INQUIRY:  exec_new = bal_q;
      default:     exec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!bus.init_en && win_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The response is registered as RESP completes, so done lands four cycles after gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++) ledger[i] <= '0;
      last_q          <= ID_WIDTH'(NUM_REQ - 1);
      id_q            <= '0;
      op_q            <= OP_INQUIRY;
      acct_q          <= '0;
      val_q           <= '0;
      bal_q           <= '0;
      new_q           <= '0;
      err_q           <= 1'b0;
      bus.gnt         <= '0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_balance <= '0;
    end else begin
      bus.gnt   <= '0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.init_en) begin
            ledger[bus.init_acct] <= bus.init_balance;
          end else if (win_valid) begin
            id_q    <= win_idx;
            op_q    <= sel_op;
            acct_q  <= sel_acct;
            val_q   <= sel_val;
            last_q  <= win_idx;
            bus.gnt <= win_onehot;
          end
        end
        ST_READ: bal_q <= ledger[acct_q];
        ST_EXEC: begin
          err_q <= exec_err;
          new_q <= exec_new;
        end
        ST_WRITE: if (!err_q && op_q != OP_INQUIRY) ledger[acct_q] <= new_q;
        ST_RESP: begin
          bus.done        <= 1'b1;
          bus.error       <= err_q;
          bus.rsp_id      <= id_q;
          bus.rsp_balance <= new_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/atm_ledger_arbiter.md
ATM_LEDGER_ARBITER -- requirements
Module: atm_ledger_arbiter

Interface
REQ-001 SHALL have parameter BALANCE_WIDTH, default 20, width of every balance/value bus.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of ATM session requesters.
REQ-003 SHALL have parameter NUM_ACCT, default 8, number of ledger accounts (account index 3 bits).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NUM_REQ  per-requester transaction request, level, held until gnt.
REQ-007 req_op  input  2*NUM_REQ  per-requester opcode: withdraw 2'b00, deposit 2'b01, inquiry 2'b10, 2'b11 illegal.
REQ-008 req_acct  input  3*NUM_REQ  per-requester account index.
REQ-009 req_value  input  BALANCE_WIDTH*NUM_REQ  per-requester amount; ignored for inquiry.
REQ-010 init_en, init_acct[2:0], init_balance[BALANCE_WIDTH-1:0]  input  ledger preload port.
REQ-011 gnt  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 error  output  1  valid with done; transaction rejected, ledger unchanged.
REQ-015 rsp_id  output  2  requester index of the completing transaction, valid with done.
REQ-016 rsp_balance  output  BALANCE_WIDTH  account balance after the transaction, valid with done.

Function
REQ-017 SHALL hold NUM_ACCT x BALANCE_WIDTH ledger registers, single shared read-modify-write datapath.
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WRITE, RESP; sequence IDLE->READ->EXEC->WRITE->RESP->IDLE, no skips, no stalls.
REQ-019 IDLE with any req high and init_en low: latch winner's id/op/acct/value, pulse gnt[winner] in the following cycle (READ), go READ.
REQ-020 Arbitration SHALL be round-robin: search starts at last-granted index + 1, wrapping modulo NUM_REQ.
REQ-021 READ: capture ledger[acct] into working register.
REQ-022 EXEC withdraw: value > balance -> error; else new = balance - value; value == balance legal, result 0.
REQ-023 EXEC deposit: balance + value > 2^BALANCE_WIDTH-1 -> error, no wrap; else new = balance + value.
REQ-024 EXEC inquiry: new = balance, never error; opcode 2'b11 -> error.
REQ-025 WRITE: update ledger[acct] only when no error; error or inquiry leaves ledger untouched.
REQ-026 RESP: done=1 for exactly one cycle with error, rsp_id, rsp_balance (unchanged balance on error); done is 4 cycles after gnt.
REQ-027 done, error, gnt SHALL be 0 outside their defined cycles; rsp_id/rsp_balance hold last value.
REQ-028 Requester SHALL deassert req in the cycle after gnt; req still high in IDLE after RESP is a new request.
REQ-029 init_en honored only in IDLE: writes init_balance to ledger[init_acct] that edge; has priority over req (req waits one cycle).
REQ-030 init_en while busy SHALL be ignored.
REQ-031 Two requests to the same account SHALL serialize; the second sees the first's committed balance.

Reset
REQ-032 rst high SHALL force IDLE, clear all ledger entries to 0, set last-granted pointer to NUM_REQ-1 (requester 0 wins first).
REQ-033 rst SHALL clear gnt, busy, done, error, rsp_id, rsp_balance to 0.
REQ-034 rst mid-transaction SHALL abort: no ledger write, no done pulse.

Structure
REQ-035 Opcode encodings, state encodings and default widths SHALL live in shared package atm_pkg.
REQ-036 Round-robin selection SHALL be sub-module rr_arbiter (req, last pointer -> one-hot winner, index).

Verification
REQ-037 Preload acct 2 = 500; req0 withdraw 200 acct 2 -> gnt[0] one cycle, done 4 cycles later, error=0, rsp_balance=300, ledger[2]=300.
REQ-038 acct 1 = 100; withdraw 101 -> error=1, rsp_balance=100, ledger unchanged; withdraw 100 -> rsp_balance=0, error=0.
REQ-039 acct 0 = 2^20-10; deposit 10 -> error=1, balance unchanged; deposit 9 -> rsp_balance=2^20-1.
REQ-040 req[3:0]=4'b1111 held continuously -> grant order 0,1,2,3,0; each done rsp_id matches grant order.
REQ-041 init_en and req0 same IDLE cycle -> ledger written, gnt[0] one cycle later; init_en during EXEC -> no effect.
REQ-042 rst asserted in WRITE of deposit 50 to acct 4 = 70 -> no done, ledger[4]=0, next grant goes to requester 0.
